// File: rtl/issue_queue_pair.sv
// Dual-issue front end: a FIFO of fetched instruction pairs that issues zero,
// one or two instructions per cycle from the head into ID slots 0/1.
module issue_queue_pair #(
    parameter int QDEPTH    = 4,
    parameter int MEM_PORTS = 1,
    parameter int CHECK_WAW = 1,
    parameter int CNT_W     = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      fetch_valid,
    output logic                      fetch_ready,
    input  logic [31:0]               fetch_inst0,
    input  logic [31:0]               fetch_inst1,
    input  logic [5:0]                fetch_ctrl0,
    input  logic [5:0]                fetch_ctrl1,
    input  logic                      issue_stall,
    output logic                      issue_valid0,
    output logic                      issue_valid1,
    output logic [31:0]               issue_inst0,
    output logic [31:0]               issue_inst1,
    output logic [5:0]                issue_ctrl0,
    output logic [5:0]                issue_ctrl1,
    output logic [$clog2(QDEPTH):0]   q_count,
    output logic [CNT_W-1:0]          dual_cnt,
    output logic [CNT_W-1:0]          single_cnt
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;

    // Control bit positions: {memread,memwrite,branch,jump,regwrite,regdst}
    localparam int C_MEMREAD  = 5;
    localparam int C_MEMWRITE = 4;
    localparam int C_BRANCH   = 3;
    localparam int C_JUMP     = 2;
    localparam int C_REGWRITE = 1;
    localparam int C_REGDST   = 0;

    localparam logic [CW-1:0] READY_MAX = CW'(QDEPTH - 2);

    logic [31:0]   q_inst [QDEPTH];
    logic [5:0]    q_ctrl [QDEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] head1;
    logic [PW-1:0] tail1;
    logic [CW-1:0] count;

    logic [31:0]   h0_inst;
    logic [31:0]   h1_inst;
    logic [5:0]    h0_ctrl;
    logic [5:0]    h1_ctrl;
    logic [4:0]    dest0;
    logic [4:0]    dest1;
    logic [4:0]    rs1;
    logic [4:0]    rt1;
    logic          pair_block;
    logic [1:0]    n_issue;
    logic          push;
    logic [CW-1:0] count_next;

    assign head1   = head + PW'(1);
    assign tail1   = tail + PW'(1);
    assign h0_inst = q_inst[head];
    assign h1_inst = q_inst[head1];
    assign h0_ctrl = q_ctrl[head];
    assign h1_ctrl = q_ctrl[head1];

    assign dest0 = h0_ctrl[C_REGDST] ? h0_inst[15:11] : h0_inst[20:16];
    assign dest1 = h1_ctrl[C_REGDST] ? h1_inst[15:11] : h1_inst[20:16];
    assign rs1   = h1_inst[25:21];
    assign rt1   = h1_inst[20:16];

    assign fetch_ready = (count <= READY_MAX);
    assign push        = fetch_valid && fetch_ready && !flush;
    assign q_count     = count;

    // Any one of these rules forces the head instruction to issue alone.
    always_comb begin
        pair_block = 1'b0;
        if (h0_ctrl[C_BRANCH] || h0_ctrl[C_JUMP] || h1_ctrl[C_BRANCH] || h1_ctrl[C_JUMP])
            pair_block = 1'b1;
        if (MEM_PORTS == 1 && (h0_ctrl[C_MEMREAD] || h0_ctrl[C_MEMWRITE])
                           && (h1_ctrl[C_MEMREAD] || h1_ctrl[C_MEMWRITE]))
            pair_block = 1'b1;
        if (h0_ctrl[C_REGWRITE] && dest0 != 5'd0 &&
            (dest0 == rs1 ||
             (dest0 == rt1 && (h1_ctrl[C_REGDST] || h1_ctrl[C_MEMWRITE] || h1_ctrl[C_BRANCH]))))
            pair_block = 1'b1;
        if (CHECK_WAW != 0 && h0_ctrl[C_REGWRITE] && h1_ctrl[C_REGWRITE] &&
            dest0 == dest1 && dest0 != 5'd0)
            pair_block = 1'b1;
    end

    always_comb begin
        n_issue = 2'd0;
        if (count == '0)
            n_issue = 2'd0;
        else if (count == CW'(1) || pair_block)
            n_issue = 2'd1;
        else
            n_issue = 2'd2;
    end

    always_comb begin
        count_next = count;
        if (!issue_stall)
            count_next = count_next - CW'(n_issue);
        if (push)
            count_next = count_next + CW'(2);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_inst[tail]  <= fetch_inst0;
            q_ctrl[tail]  <= fetch_ctrl0;
            q_inst[tail1] <= fetch_inst1;
            q_ctrl[tail1] <= fetch_ctrl1;
        end
    end

    // Flush beats stall; a stall freezes the issue slots and counters but not pushes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            issue_valid0 <= 1'b0;
            issue_valid1 <= 1'b0;
            issue_inst0  <= '0;
            issue_inst1  <= '0;
            issue_ctrl0  <= '0;
            issue_ctrl1  <= '0;
            dual_cnt     <= '0;
            single_cnt   <= '0;
        end else if (flush) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            issue_valid0 <= 1'b0;
            issue_valid1 <= 1'b0;
            issue_inst0  <= '0;
            issue_inst1  <= '0;
            issue_ctrl0  <= '0;
            issue_ctrl1  <= '0;
        end else begin
            count <= count_next;
            if (push)
                tail <= tail + PW'(2);
            if (!issue_stall) begin
                head         <= head + PW'(n_issue);
                issue_valid0 <= (n_issue != 2'd0);
                issue_valid1 <= (n_issue == 2'd2);
                issue_inst0  <= (n_issue != 2'd0) ? h0_inst : 32'h0;
                issue_ctrl0  <= (n_issue != 2'd0) ? h0_ctrl : 6'h0;
                issue_inst1  <= (n_issue == 2'd2) ? h1_inst : 32'h0;
                issue_ctrl1  <= (n_issue == 2'd2) ? h1_ctrl : 6'h0;
                if (n_issue == 2'd2 && dual_cnt != '1)
                    dual_cnt <= dual_cnt + 1'b1;
                if (n_issue == 2'd1 && single_cnt != '1)
                    single_cnt <= single_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_issue_queue_pair.sv
// Randomized scoreboard bench for issue_queue_pair: a queue-based reference
// model predicts each cycle's outputs, a monitor compares after every edge.
module tb_issue_queue_pair;

    localparam int QDEPTH    = 4;
    localparam int MEM_PORTS = 1;
    localparam int CHECK_WAW = 1;
    localparam int CNT_W     = 4;
    localparam int QW        = $clog2(QDEPTH) + 1;
    localparam int CNT_MAX   = (1 << CNT_W) - 1;

    typedef struct {
        logic [31:0] inst;
        logic [5:0]  ctrl;
    } entry_t;

    typedef struct {
        bit          v0;
        bit          v1;
        logic [31:0] i0;
        logic [31:0] i1;
        logic [5:0]  c0;
        logic [5:0]  c1;
        int          qc;
        bit          rdy;
        int          dual;
        int          single;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              fetch_valid;
    logic              fetch_ready;
    logic [31:0]       fetch_inst0;
    logic [31:0]       fetch_inst1;
    logic [5:0]        fetch_ctrl0;
    logic [5:0]        fetch_ctrl1;
    logic              issue_stall;
    logic              issue_valid0;
    logic              issue_valid1;
    logic [31:0]       issue_inst0;
    logic [31:0]       issue_inst1;
    logic [5:0]        issue_ctrl0;
    logic [5:0]        issue_ctrl1;
    logic [QW-1:0]     q_count;
    logic [CNT_W-1:0]  dual_cnt;
    logic [CNT_W-1:0]  single_cnt;

    int tests_run    = 0;
    int tests_failed = 0;

    entry_t mq[$];
    exp_t   exp_q[$];
    exp_t   m_out;

    issue_queue_pair #(
        .QDEPTH(QDEPTH), .MEM_PORTS(MEM_PORTS), .CHECK_WAW(CHECK_WAW), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .fetch_inst0(fetch_inst0), .fetch_inst1(fetch_inst1),
        .fetch_ctrl0(fetch_ctrl0), .fetch_ctrl1(fetch_ctrl1),
        .issue_stall(issue_stall),
        .issue_valid0(issue_valid0), .issue_valid1(issue_valid1),
        .issue_inst0(issue_inst0), .issue_inst1(issue_inst1),
        .issue_ctrl0(issue_ctrl0), .issue_ctrl1(issue_ctrl1),
        .q_count(q_count), .dual_cnt(dual_cnt), .single_cnt(single_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] destOf(entry_t e);
        return e.ctrl[0] ? e.inst[15:11] : e.inst[20:16];
    endfunction

    // Pairing rules: ctrl = {memread,memwrite,branch,jump,regwrite,regdst}
    function automatic bit canPair(entry_t a, entry_t b);
        logic [4:0] d0 = destOf(a);
        logic [4:0] d1 = destOf(b);
        logic [4:0] rs = b.inst[25:21];
        logic [4:0] rt = b.inst[20:16];
        bool_chk: begin end
        if (a.ctrl[3] || a.ctrl[2] || b.ctrl[3] || b.ctrl[2]) return 1'b0;
        if (MEM_PORTS == 1 && (a.ctrl[5] || a.ctrl[4]) && (b.ctrl[5] || b.ctrl[4])) return 1'b0;
        if (a.ctrl[1] && d0 != 0 && (d0 == rs || (d0 == rt && (b.ctrl[0] || b.ctrl[4] || b.ctrl[3]))))
            return 1'b0;
        if (CHECK_WAW != 0 && a.ctrl[1] && b.ctrl[1] && d0 == d1 && d0 != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic modelReset();
        mq.delete();
        m_out = '{v0: 0, v1: 0, i0: 0, i1: 0, c0: 0, c1: 0, qc: 0, rdy: 1, dual: 0, single: 0};
    endtask

    // Advance the reference model by one clock edge and queue its prediction.
    task automatic modelStep(input bit v, input entry_t e0, input entry_t e1,
                             input bit stall, input bit fl);
        bit rdy = (QDEPTH - mq.size()) >= 2;
        int n;
        if (fl) begin
            mq.delete();
            m_out.v0 = 0; m_out.v1 = 0;
            m_out.i0 = 0; m_out.i1 = 0;
            m_out.c0 = 0; m_out.c1 = 0;
        end else begin
            if (!stall) begin
                if (mq.size() == 0)                          n = 0;
                else if (mq.size() == 1 || !canPair(mq[0], mq[1])) n = 1;
                else                                         n = 2;
                m_out.v0 = (n >= 1);
                m_out.v1 = (n == 2);
                m_out.i0 = (n >= 1) ? mq[0].inst : 32'h0;
                m_out.c0 = (n >= 1) ? mq[0].ctrl : 6'h0;
                m_out.i1 = (n == 2) ? mq[1].inst : 32'h0;
                m_out.c1 = (n == 2) ? mq[1].ctrl : 6'h0;
                if (n == 2 && m_out.dual < CNT_MAX)   m_out.dual++;
                if (n == 1 && m_out.single < CNT_MAX) m_out.single++;
                repeat (n) void'(mq.pop_front());
            end
            if (v && rdy) begin
                mq.push_back(e0);
                mq.push_back(e1);
            end
        end
        m_out.qc  = mq.size();
        m_out.rdy = (QDEPTH - mq.size()) >= 2;
        exp_q.push_back(m_out);
    endtask

    task automatic checkOutput(input exp_t e, input string name);
        tests_run++;
        if (issue_valid0 !== e.v0 || issue_valid1 !== e.v1 ||
            issue_inst0 !== e.i0 || issue_inst1 !== e.i1 ||
            issue_ctrl0 !== e.c0 || issue_ctrl1 !== e.c1 ||
            q_count !== QW'(e.qc) || fetch_ready !== e.rdy ||
            dual_cnt !== CNT_W'(e.dual) || single_cnt !== CNT_W'(e.single)) begin
            tests_failed++;
            $display("[TB] FAIL %s t=%0t: got v=%b%b i0=%h i1=%h c0=%h c1=%h qc=%0d rdy=%b dual=%0d single=%0d; want v=%b%b i0=%h i1=%h c0=%h c1=%h qc=%0d rdy=%b dual=%0d single=%0d",
                     name, $time, issue_valid0, issue_valid1, issue_inst0, issue_inst1,
                     issue_ctrl0, issue_ctrl1, q_count, fetch_ready, dual_cnt, single_cnt,
                     e.v0, e.v1, e.i0, e.i1, e.c0, e.c1, e.qc, e.rdy, e.dual, e.single);
        end
    endtask

    task automatic applyStimulus(input bit v, input logic [31:0] i0, input logic [5:0] c0,
                                 input logic [31:0] i1, input logic [5:0] c1,
                                 input bit stall, input bit fl);
        entry_t e0, e1;
        @(negedge clk);
        fetch_valid = v;
        fetch_inst0 = i0; fetch_ctrl0 = c0;
        fetch_inst1 = i1; fetch_ctrl1 = c1;
        issue_stall = stall;
        flush       = fl;
        e0 = '{inst: i0, ctrl: c0};
        e1 = '{inst: i1, ctrl: c1};
        modelStep(v, e0, e1, stall, fl);
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic midReset();
        @(negedge clk);
        fetch_valid = 0; issue_stall = 0; flush = 0;
        rst_n = 0;
        #1;
        modelReset();
        checkOutput(m_out, "async_reset");
        @(negedge clk);
        rst_n = 1;
    endtask

    function automatic logic [31:0] randInst();
        logic [31:0] r = $urandom;
        r[25:21] = 5'($urandom_range(0, 7));
        r[20:16] = 5'($urandom_range(0, 7));
        r[15:11] = 5'($urandom_range(0, 7));
        return r;
    endfunction

    function automatic logic [5:0] randCtrl();
        logic [5:0] c = 6'($urandom_range(0, 63));
        if ($urandom_range(0, 3) != 0) c[3:2] = 2'b00;
        return c;
    endfunction

    // Monitor: compare each queued prediction just after the edge it belongs to.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) checkOutput(exp_q.pop_front(), "cycle");
        end
    end

    localparam logic [31:0] ADD3 = 32'h00221820;  // add $3,$1,$2
    localparam logic [31:0] SUB6 = 32'h00853022;  // sub $6,$4,$5
    localparam logic [31:0] ADD5 = 32'h00642820;  // add $5,$3,$4
    localparam logic [31:0] LW8  = 32'h8C280000;  // lw  $8,0($1)
    localparam logic [31:0] SW9  = 32'hAC490004;  // sw  $9,4($2)
    localparam logic [31:0] BEQ  = 32'h10220004;  // beq $1,$2
    localparam logic [5:0]  C_R  = 6'b000011;
    localparam logic [5:0]  C_LW = 6'b100010;
    localparam logic [5:0]  C_SW = 6'b010000;
    localparam logic [5:0]  C_BR = 6'b001000;

    initial begin
        rst_n = 0; flush = 0; fetch_valid = 0; issue_stall = 0;
        fetch_inst0 = 0; fetch_inst1 = 0; fetch_ctrl0 = 0; fetch_ctrl1 = 0;
        modelReset();
        #2;
        checkOutput(m_out, "reset_state");
        @(negedge clk);
        rst_n = 1;

        applyStimulus(1, ADD3, C_R, SUB6, C_R, 0, 0); idle(3);
        applyStimulus(1, ADD3, C_R, ADD5, C_R, 0, 0); idle(3);
        applyStimulus(1, LW8, C_LW, SW9, C_SW, 0, 0); idle(3);
        applyStimulus(1, ADD3, C_R, BEQ, C_BR, 0, 0); idle(3);
        applyStimulus(1, BEQ, C_BR, ADD3, C_R, 0, 0); idle(3);

        applyStimulus(1, ADD3, C_R, SUB6, C_R, 1, 0);
        applyStimulus(1, LW8, C_LW, SW9, C_SW, 1, 0);
        applyStimulus(1, ADD5, C_R, ADD3, C_R, 1, 0);
        applyStimulus(1, ADD5, C_R, ADD3, C_R, 0, 0);
        idle(4);

        applyStimulus(1, ADD3, C_R, ADD5, C_R, 1, 0);
        applyStimulus(1, LW8, C_LW, SW9, C_SW, 0, 0);
        applyStimulus(1, SUB6, C_R, SUB6, C_R, 0, 1);
        idle(2);

        for (int k = 0; k < 800; k++) begin
            if (k == 400) midReset();
            applyStimulus($urandom_range(0, 9) < 7, randInst(), randCtrl(),
                          randInst(), randCtrl(),
                          $urandom_range(0, 3) == 0, $urandom_range(0, 24) == 0);
        end
        idle(2);

        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
        if (exp_q.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL drain: %0d predictions left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
